// File: rtl/sim_run_ctrl.sv
// Run/dump sequencer: holds the CPU in reset, runs it for a bounded count or until halt, then streams the regfile out.
// Registered outputs; each dump entry takes two read cycles plus one OUT cycle, and an OUT entry holds until dump_ready.
module sim_run_ctrl #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int IDXW       = 5,
    parameter int RST_CYCLES = 1,
    parameter int RUN_CYCLES = 100,
    parameter int SKIP_ZERO  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            halt,
    output logic            cpu_rst_n,
    output logic            cpu_run,
    output logic [IDXW-1:0] rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [IDXW-1:0] dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic [31:0]     cycles_run,
    output logic            done
);

    typedef enum logic [2:0] {
        S_RESET,
        S_RUN,
        S_RD,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [IDXW-1:0] FIRST_IDX = (SKIP_ZERO != 0) ? IDXW'(1) : '0;
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NREGS - 1);
    localparam logic [31:0]     RST_LAST  = 32'(RST_CYCLES - 1);
    localparam logic [31:0]     RUN_LIM   = 32'(RUN_CYCLES);

    state_t          state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            cpu_rst_n_q, cpu_rst_n_d;
    logic            cpu_run_q, cpu_run_d;
    logic [IDXW-1:0] rf_raddr_q, rf_raddr_d;
    logic            dump_valid_q, dump_valid_d;
    logic [IDXW-1:0] dump_idx_q, dump_idx_d;
    logic [XLEN-1:0] dump_data_q, dump_data_d;
    logic [31:0]     cycles_q, cycles_d;
    logic            done_q, done_d;
    logic [31:0]     cycles_inc;

    assign cycles_inc = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cpu_rst_n_d  = cpu_rst_n_q;
        cpu_run_d    = cpu_run_q;
        rf_raddr_d   = rf_raddr_q;
        dump_valid_d = dump_valid_q;
        dump_idx_d   = dump_idx_q;
        dump_data_d  = dump_data_q;
        cycles_d     = cycles_q;
        done_d       = done_q;

        case (state_q)
            S_RESET: begin
                cpu_rst_n_d = 1'b0;
                cpu_run_d   = 1'b0;
                if (cnt_q == RST_LAST) begin
                    cpu_rst_n_d = 1'b1;
                    cpu_run_d   = 1'b1;
                    cnt_d       = 32'd0;
                    state_d     = S_RUN;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RUN: begin
                // The halt-sampling cycle is itself a run cycle, so count first.
                cycles_d = cycles_inc;
                if (cycles_inc == RUN_LIM || halt) begin
                    cpu_run_d  = 1'b0;
                    rf_raddr_d = FIRST_IDX;
                    cnt_d      = 32'd0;
                    state_d    = S_RD;
                end
            end
            S_RD: begin
                // First cycle lets the regfile register the new address; capture on the second.
                if (cnt_q == 32'd0) begin
                    cnt_d = 32'd1;
                end else begin
                    cnt_d        = 32'd0;
                    dump_data_d  = rf_rdata;
                    dump_idx_d   = rf_raddr_q;
                    dump_valid_d = 1'b1;
                    state_d      = S_OUT;
                end
            end
            S_OUT: begin
                if (dump_ready) begin
                    dump_valid_d = 1'b0;
                    if (dump_idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        rf_raddr_d = dump_idx_q + 1'b1;
                        state_d    = S_RD;
                    end
                end
            end
            S_DONE: begin
                cpu_run_d = 1'b0;
                if (start) begin
                    done_d      = 1'b0;
                    cycles_d    = 32'd0;
                    cpu_rst_n_d = 1'b0;
                    cnt_d       = 32'd0;
                    state_d     = S_RESET;
                end
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RESET;
            cnt_q        <= 32'd0;
            cpu_rst_n_q  <= 1'b0;
            cpu_run_q    <= 1'b0;
            rf_raddr_q   <= '0;
            dump_valid_q <= 1'b0;
            dump_idx_q   <= '0;
            dump_data_q  <= '0;
            cycles_q     <= 32'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            cpu_run_q    <= cpu_run_d;
            rf_raddr_q   <= rf_raddr_d;
            dump_valid_q <= dump_valid_d;
            dump_idx_q   <= dump_idx_d;
            dump_data_q  <= dump_data_d;
            cycles_q     <= cycles_d;
            done_q       <= done_d;
        end
    end

    assign cpu_rst_n  = cpu_rst_n_q;
    assign cpu_run    = cpu_run_q;
    assign rf_raddr   = rf_raddr_q;
    assign dump_valid = dump_valid_q;
    assign dump_idx   = dump_idx_q;
    assign dump_data  = dump_data_q;
    assign cycles_run = cycles_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: a default instance plus a small-config instance, each with a registered regfile model.
module tb_sim_run_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start_drv, halt_drv, ready_drv;
    logic sel;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Default instance
    logic        c1_rst_n, c1_run, v1, done1;
    logic [4:0]  raddr1, idx1;
    logic [31:0] rdata1, data1, cyc1;
    // Small instance: NREGS=8, IDXW=3, RST_CYCLES=4, RUN_CYCLES=20, SKIP_ZERO=0
    logic        c2_rst_n, c2_run, v2, done2;
    logic [2:0]  raddr2, idx2;
    logic [31:0] rdata2, data2, cyc2;

    logic [31:0] rf1 [32];
    logic [31:0] rf2 [8];

    initial begin
        for (int i = 0; i < 32; i++) rf1[i] = 32'h1000 + i;
        for (int i = 0; i < 8; i++)  rf2[i] = 32'h1000 + i;
    end

    always @(posedge clk) begin
        rdata1 <= rf1[raddr1];
        rdata2 <= rf2[raddr2];
    end

    sim_run_ctrl u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (sel ? 1'b0 : start_drv),
        .halt       (sel ? 1'b0 : halt_drv),
        .cpu_rst_n  (c1_rst_n),
        .cpu_run    (c1_run),
        .rf_raddr   (raddr1),
        .rf_rdata   (rdata1),
        .dump_valid (v1),
        .dump_ready (sel ? 1'b1 : ready_drv),
        .dump_idx   (idx1),
        .dump_data  (data1),
        .cycles_run (cyc1),
        .done       (done1)
    );

    sim_run_ctrl #(
        .XLEN(32), .NREGS(8), .IDXW(3), .RST_CYCLES(4), .RUN_CYCLES(20), .SKIP_ZERO(0)
    ) u_dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (sel ? start_drv : 1'b0),
        .halt       (sel ? halt_drv : 1'b0),
        .cpu_rst_n  (c2_rst_n),
        .cpu_run    (c2_run),
        .rf_raddr   (raddr2),
        .rf_rdata   (rdata2),
        .dump_valid (v2),
        .dump_ready (sel ? ready_drv : 1'b1),
        .dump_idx   (idx2),
        .dump_data  (data2),
        .cycles_run (cyc2),
        .done       (done2)
    );

    logic        m_cpu_rst_n, m_cpu_run, m_valid, m_done;
    logic [4:0]  m_idx, m_raddr;
    logic [31:0] m_data, m_cyc;

    assign m_cpu_rst_n = sel ? c2_rst_n : c1_rst_n;
    assign m_cpu_run   = sel ? c2_run : c1_run;
    assign m_valid     = sel ? v2 : v1;
    assign m_done      = sel ? done2 : done1;
    assign m_idx       = sel ? {2'b00, idx2} : idx1;
    assign m_raddr     = sel ? {2'b00, raddr2} : raddr1;
    assign m_data      = sel ? data2 : data1;
    assign m_cyc       = sel ? cyc2 : cyc1;

    int          r_rst_low, r_run_hi, r_n_ent, r_bad_order, r_bad_data, r_unstable, r_last, r_timeout;
    logic [31:0] r_cyc;

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Observes one run+dump sequence from the current negedge, driving halt/start/ready; returns measurements only.
    task automatic collect(input int halt_at, input int ready_mode, input int start_at, input int stop_idx,
                           input int first_idx,
                           output int rst_low, output int run_hi, output int n_ent, output int bad_order,
                           output int bad_data, output int unstable, output int last_idx,
                           output logic [31:0] cyc, output int timed_out);
        int          exp_idx;
        int          phase;
        logic        stall;
        logic [4:0]  p_idx;
        logic [31:0] p_data;
        bit          fin;
        rst_low = 0; run_hi = 0; n_ent = 0; bad_order = 0; bad_data = 0; unstable = 0;
        last_idx = -1; cyc = '0; timed_out = 1;
        exp_idx = first_idx; phase = 0; stall = 1'b0; p_idx = '0; p_data = '0; fin = 0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            if (m_cpu_rst_n === 1'b0) rst_low++;
            if (m_cpu_run === 1'b1) run_hi++;
            if (stall && (m_valid !== 1'b1 || m_idx !== p_idx || m_data !== p_data)) unstable++;
            if (m_done === 1'b1) begin
                fin = 1; timed_out = 0; cyc = m_cyc;
            end else if (stop_idx >= 0 && m_valid === 1'b1 && int'(m_idx) == stop_idx) begin
                fin = 1; timed_out = 0;
            end else begin
                halt_drv  = (halt_at > 0 && m_cpu_run === 1'b1 && run_hi == halt_at);
                start_drv = (start_at > 0 && m_cpu_run === 1'b1 && run_hi == start_at);
                ready_drv = (ready_mode == 0) ? 1'b1 : (phase % 3 == 2);
                phase++;
                stall  = (m_valid === 1'b1) && !ready_drv;
                p_idx  = m_idx;
                p_data = m_data;
                if (m_valid === 1'b1 && ready_drv) begin
                    n_ent++;
                    if (int'(m_idx) != exp_idx) bad_order++;
                    if (m_data !== 32'h1000 + {27'd0, m_idx}) bad_data++;
                    last_idx = int'(m_idx);
                    exp_idx++;
                end
                @(negedge clk);
            end
        end
        halt_drv = 1'b0; start_drv = 1'b0; ready_drv = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (m_cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_rst_n: got %b expected 0", m_cpu_rst_n); end
        n_tests++; if (m_cpu_run !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_run: got %b expected 0", m_cpu_run); end
        n_tests++; if (m_raddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_raddr: got %0d expected 0", m_raddr); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dump_valid: got %b expected 0", m_valid); end
        n_tests++; if (m_idx !== 5'd0) begin n_fail++; $display("FAIL reset_dump_idx: got %0d expected 0", m_idx); end
        n_tests++; if (m_data !== 32'd0) begin n_fail++; $display("FAIL reset_dump_data: got %h expected 0", m_data); end
        n_tests++; if (m_cyc !== 32'd0) begin n_fail++; $display("FAIL reset_cycles_run: got %0d expected 0", m_cyc); end
        n_tests++; if (m_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", m_done); end
    endtask

    task automatic test_default_run();
        apply_reset();
        collect(0, 0, 0, -1, 1, r_rst_low, r_run_hi, r_n_ent, r_bad_order, r_bad_data, r_unstable, r_last, r_cyc, r_timeout);
        n_tests++; if (r_timeout != 0) begin n_fail++; $display("FAIL default_done_timeout: got %0d expected 0", r_timeout); end
        n_tests++; if (r_rst_low != 1) begin n_fail++; $display("FAIL default_rst_low: got %0d expected 1", r_rst_low); end
        n_tests++; if (r_run_hi != 100) begin n_fail++; $display("FAIL default_run_hi: got %0d expected 100", r_run_hi); end
        n_tests++; if (r_cyc !== 32'd100) begin n_fail++; $display("FAIL default_cycles_run: got %0d expected 100", r_cyc); end
        n_tests++; if (r_n_ent != 31) begin n_fail++; $display("FAIL default_entries: got %0d expected 31", r_n_ent); end
        n_tests++; if (r_bad_order != 0) begin n_fail++; $display("FAIL default_order: got %0d expected 0", r_bad_order); end
        n_tests++; if (r_bad_data != 0) begin n_fail++; $display("FAIL default_data: got %0d expected 0", r_bad_data); end
        n_tests++; if (r_last != 31) begin n_fail++; $display("FAIL default_last_idx: got %0d expected 31", r_last); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL default_valid_in_done: got %b expected 0", m_valid); end
    endtask

    task automatic test_halt();
        apply_reset();
        collect(37, 0, 0, -1, 1, r_rst_low, r_run_hi, r_n_ent, r_bad_order, r_bad_data, r_unstable, r_last, r_cyc, r_timeout);
        n_tests++; if (r_timeout != 0) begin n_fail++; $display("FAIL halt_done_timeout: got %0d expected 0", r_timeout); end
        n_tests++; if (r_run_hi != 37) begin n_fail++; $display("FAIL halt_run_hi: got %0d expected 37", r_run_hi); end
        n_tests++; if (r_cyc !== 32'd37) begin n_fail++; $display("FAIL halt_cycles_run: got %0d expected 37", r_cyc); end
        n_tests++; if (r_n_ent != 31) begin n_fail++; $display("FAIL halt_entries: got %0d expected 31", r_n_ent); end
        n_tests++; if (r_bad_data != 0) begin n_fail++; $display("FAIL halt_data: got %0d expected 0", r_bad_data); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        collect(0, 1, 0, -1, 1, r_rst_low, r_run_hi, r_n_ent, r_bad_order, r_bad_data, r_unstable, r_last, r_cyc, r_timeout);
        n_tests++; if (r_timeout != 0) begin n_fail++; $display("FAIL bp_done_timeout: got %0d expected 0", r_timeout); end
        n_tests++; if (r_unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable expected 0", r_unstable); end
        n_tests++; if (r_n_ent != 31) begin n_fail++; $display("FAIL bp_entries: got %0d expected 31", r_n_ent); end
        n_tests++; if (r_bad_order != 0) begin n_fail++; $display("FAIL bp_order: got %0d expected 0", r_bad_order); end
        n_tests++; if (r_bad_data != 0) begin n_fail++; $display("FAIL bp_data: got %0d expected 0", r_bad_data); end
        n_tests++; if (r_last != 31) begin n_fail++; $display("FAIL bp_last_idx: got %0d expected 31", r_last); end
    endtask

    task automatic test_small_cfg();
        sel = 1'b1;
        apply_reset();
        collect(0, 0, 0, -1, 0, r_rst_low, r_run_hi, r_n_ent, r_bad_order, r_bad_data, r_unstable, r_last, r_cyc, r_timeout);
        n_tests++; if (r_timeout != 0) begin n_fail++; $display("FAIL small_done_timeout: got %0d expected 0", r_timeout); end
        n_tests++; if (r_rst_low != 4) begin n_fail++; $display("FAIL small_rst_low: got %0d expected 4", r_rst_low); end
        n_tests++; if (r_run_hi != 20) begin n_fail++; $display("FAIL small_run_hi: got %0d expected 20", r_run_hi); end
        n_tests++; if (r_cyc !== 32'd20) begin n_fail++; $display("FAIL small_cycles_run: got %0d expected 20", r_cyc); end
        n_tests++; if (r_n_ent != 8) begin n_fail++; $display("FAIL small_entries: got %0d expected 8", r_n_ent); end
        n_tests++; if (r_bad_order != 0) begin n_fail++; $display("FAIL small_order: got %0d expected 0", r_bad_order); end
        n_tests++; if (r_bad_data != 0) begin n_fail++; $display("FAIL small_data: got %0d expected 0", r_bad_data); end
        n_tests++; if (r_last != 7) begin n_fail++; $display("FAIL small_last_idx: got %0d expected 7", r_last); end
        sel = 1'b0;
    endtask

    task automatic test_restart();
        apply_reset();
        // start pulsed on the 10th RUN cycle must not restart anything
        collect(0, 0, 10, -1, 1, r_rst_low, r_run_hi, r_n_ent, r_bad_order, r_bad_data, r_unstable, r_last, r_cyc, r_timeout);
        n_tests++; if (r_rst_low != 1) begin n_fail++; $display("FAIL restart_run_start_rst_low: got %0d expected 1", r_rst_low); end
        n_tests++; if (r_run_hi != 100) begin n_fail++; $display("FAIL restart_run_start_run_hi: got %0d expected 100", r_run_hi); end
        n_tests++; if (r_cyc !== 32'd100) begin n_fail++; $display("FAIL restart_run_start_cycles: got %0d expected 100", r_cyc); end
        repeat (3) @(negedge clk);
        n_tests++; if (m_done !== 1'b1) begin n_fail++; $display("FAIL restart_done_sticky: got %b expected 1", m_done); end
        n_tests++; if (m_cyc !== 32'd100) begin n_fail++; $display("FAIL restart_cycles_hold: got %0d expected 100", m_cyc); end
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        n_tests++; if (m_done !== 1'b0) begin n_fail++; $display("FAIL restart_done_clear: got %b expected 0", m_done); end
        n_tests++; if (m_cyc !== 32'd0) begin n_fail++; $display("FAIL restart_cycles_clear: got %0d expected 0", m_cyc); end
        collect(50, 0, 0, -1, 1, r_rst_low, r_run_hi, r_n_ent, r_bad_order, r_bad_data, r_unstable, r_last, r_cyc, r_timeout);
        n_tests++; if (r_timeout != 0) begin n_fail++; $display("FAIL restart_done_timeout: got %0d expected 0", r_timeout); end
        n_tests++; if (r_rst_low != 1) begin n_fail++; $display("FAIL restart_rst_low: got %0d expected 1", r_rst_low); end
        n_tests++; if (r_cyc !== 32'd50) begin n_fail++; $display("FAIL restart_cycles_run: got %0d expected 50", r_cyc); end
        n_tests++; if (r_n_ent != 31) begin n_fail++; $display("FAIL restart_entries: got %0d expected 31", r_n_ent); end
    endtask

    task automatic test_abort();
        apply_reset();
        collect(0, 0, 0, 12, 1, r_rst_low, r_run_hi, r_n_ent, r_bad_order, r_bad_data, r_unstable, r_last, r_cyc, r_timeout);
        n_tests++; if (r_timeout != 0) begin n_fail++; $display("FAIL abort_reach_idx12: got timeout %0d expected 0", r_timeout); end
        n_tests++; if (r_n_ent != 11) begin n_fail++; $display("FAIL abort_entries_before: got %0d expected 11", r_n_ent); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b expected 0", m_valid); end
        n_tests++; if (m_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", m_done); end
        n_tests++; if (m_cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL abort_cpu_rst_n: got %b expected 0", m_cpu_rst_n); end
        n_tests++; if (m_cyc !== 32'd0) begin n_fail++; $display("FAIL abort_cycles_run: got %0d expected 0", m_cyc); end
        @(negedge clk);
        rst_n = 1'b1;
        collect(0, 0, 0, -1, 1, r_rst_low, r_run_hi, r_n_ent, r_bad_order, r_bad_data, r_unstable, r_last, r_cyc, r_timeout);
        n_tests++; if (r_timeout != 0) begin n_fail++; $display("FAIL abort_rerun_timeout: got %0d expected 0", r_timeout); end
        n_tests++; if (r_rst_low != 1) begin n_fail++; $display("FAIL abort_rerun_rst_low: got %0d expected 1", r_rst_low); end
        n_tests++; if (r_cyc !== 32'd100) begin n_fail++; $display("FAIL abort_rerun_cycles: got %0d expected 100", r_cyc); end
        n_tests++; if (r_n_ent != 31) begin n_fail++; $display("FAIL abort_rerun_entries: got %0d expected 31", r_n_ent); end
        n_tests++; if (r_bad_order != 0) begin n_fail++; $display("FAIL abort_rerun_order: got %0d expected 0", r_bad_order); end
    endtask

    initial begin
        sel       = 1'b0;
        rst_n     = 1'b0;
        start_drv = 1'b0;
        halt_drv  = 1'b0;
        ready_drv = 1'b1;
        @(negedge clk);
        test_reset();
        test_default_run();
        test_halt();
        test_backpressure();
        test_small_cfg();
        test_restart();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
